// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: PC handshake, instruction memory bus and decode-side FIFO port
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  pc_in;
  logic               pc_valid;
  logic               pc_ready;
  logic               flush;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_gnt;
  logic               mem_rvalid;
  logic [INSTR_W-1:0] mem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_err;
  modport master (
    input  pc_in, pc_valid, flush, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
    output pc_ready, mem_req, mem_addr, instr_valid, instr, instr_pc, instr_err
  );
  modport slave (
    output pc_in, pc_valid, flush, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
    input  pc_ready, mem_req, mem_addr, instr_valid, instr, instr_pc, instr_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch with flushable output FIFO
module instr_fetch_unit #(
  parameter int                 ADDR_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter int                 DEPTH     = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
  input logic                 clk,
  input logic                 reset,
  instr_fetch_unit_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] fifo_instr [DEPTH];
  logic [ADDR_W-1:0]  fifo_pc [DEPTH];
  logic               fifo_err [DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               accept, mis, push, pop;
  assign accept = bus.pc_valid && bus.pc_ready;
  assign mis    = accept && bus.pc_in[1:0] != 2'b00;
  // a misaligned PC never touches memory; its NOP goes straight into the FIFO
  assign push   = mis || (state == WAIT && bus.mem_rvalid && !bus.flush);
  assign pop    = bus.instr_valid && bus.instr_ready && !bus.flush;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept && !mis ? REQ : IDLE;
      REQ:     state_nxt = bus.mem_gnt ? (bus.flush ? DROP : WAIT) : (bus.flush ? IDLE : REQ);
      WAIT:    state_nxt = bus.mem_rvalid ? IDLE : (bus.flush ? DROP : WAIT);
      DROP:    state_nxt = bus.mem_rvalid ? IDLE : DROP;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.pc_ready    = state == IDLE && !bus.flush && count < CW'(DEPTH) && !reset;
    bus.mem_req     = state == REQ;
    bus.mem_addr    = {pc_q[ADDR_W-1:2], 2'b00};
    bus.instr_valid = count != '0;
    bus.instr       = fifo_instr[rd_ptr];
    bus.instr_pc    = fifo_pc[rd_ptr];
    bus.instr_err   = fifo_err[rd_ptr];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_q   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
        fifo_err[i]   <= 1'b0;
      end
    end else begin
      if (accept) pc_q <= bus.pc_in;
      if (push) begin
        fifo_instr[wr_ptr] <= mis ? NOP_INSTR : bus.mem_rdata;
        fifo_pc[wr_ptr]    <= mis ? bus.pc_in : pc_q;
        fifo_err[wr_ptr]   <= mis;
      end
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        wr_ptr <= wr_ptr + PW'(push);
        rd_ptr <= rd_ptr + PW'(pop);
        count  <= count + CW'(push) - CW'(pop);
      end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: vector table, directed corner sequences and randomized queue-model check
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 1'b0;
  logic reset;
  int tests = 0;
  int fails = 0;
  instr_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) b();
  instr_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .bus(b.master)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          gd;
    int          rd;
    logic [31:0] ins;
    logic        err;
    int          lat;
  } vec_t;
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        err;
  } ent_t;
  vec_t tv[7];
  ent_t exq[$];
  bit auto_mem = 0;
  bit gpend = 0;
  logic [31:0] gaddr = '0;
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h0F0F};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  // zero-wait memory: grant in the request cycle, data the following cycle
  task automatic step();
    @(negedge clk);
    if (auto_mem) begin
      b.mem_rvalid = gpend;
      b.mem_rdata  = memf(gaddr);
      gpend        = b.mem_req;
      gaddr        = b.mem_addr;
      b.mem_gnt    = b.mem_req;
    end
  endtask
  task automatic send(input logic [31:0] pc, input int lim, output bit ok);
    b.pc_in = pc;
    b.pc_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < lim && !ok; k++) begin
      #1 ok = b.pc_ready;
      step();
    end
    b.pc_valid = 1'b0;
  endtask
  task automatic wait_valid(input int lim);
    #1;
    for (int k = 0; k < lim && !b.instr_valid; k++) begin
      step();
      #1;
    end
    chk("wait_valid", b.instr_valid, 1);
  endtask
  task automatic pop1();
    b.instr_ready = 1'b1;
    step();
    b.instr_ready = 1'b0;
    #1;
  endtask
  task automatic clear_mem();
    auto_mem = 0;
    gpend = 0;
    b.mem_gnt = 0;
    b.mem_rvalid = 0;
    b.mem_rdata = '0;
  endtask
  initial begin
    bit ok, saw, acc, pp, outst, oreq;
    int cyc, mph, mw;
    logic [31:0] opc, maddr;
    logic [31:0] got_pc[$];
    logic [31:0] got_ins[$];
    logic [31:0] order[3];
    tv[0] = '{32'h00000000, 32'h00500093, 0, 0, 32'h00500093, 1'b0, 3};
    tv[1] = '{32'h00000006, 32'hFFFFFFFF, 0, 0, NOP,          1'b1, 1};
    tv[2] = '{32'h00000104, 32'hCAFEF00D, 2, 1, 32'hCAFEF00D, 1'b0, 6};
    tv[3] = '{32'hFFFFFFFC, 32'h12345678, 1, 0, 32'h12345678, 1'b0, 4};
    tv[4] = '{32'h00000003, 32'hFFFFFFFF, 0, 0, NOP,          1'b1, 1};
    tv[5] = '{32'h80000001, 32'hFFFFFFFF, 0, 0, NOP,          1'b1, 1};
    tv[6] = '{32'h00000020, 32'hA5A5A5A5, 0, 2, 32'hA5A5A5A5, 1'b0, 5};
    order = '{32'h0, 32'h4, 32'h8};
    reset = 1'b1;
    b.pc_in = '0; b.pc_valid = 0; b.flush = 0; b.instr_ready = 0;
    clear_mem();
    step(); step(); #1;
    chk("rst_pc_ready", b.pc_ready, 0);
    chk("rst_mem_req", b.mem_req, 0);
    chk("rst_mem_addr", b.mem_addr, 0);
    chk("rst_instr_valid", b.instr_valid, 0);
    chk("rst_instr", b.instr, 0);
    chk("rst_instr_pc", b.instr_pc, 0);
    chk("rst_instr_err", b.instr_err, 0);
    reset = 1'b0;
    #1 chk("rel_pc_ready", b.pc_ready, 1);
    for (int i = 0; i < 7; i++) begin
      b.pc_in = tv[i].pc;
      b.pc_valid = 1'b1;
      #1 chk("vec_ready", b.pc_ready, 1);
      step();
      b.pc_valid = 1'b0;
      cyc = 0;
      saw = 0;
      for (int k = 1; k <= 20; k++) begin
        b.mem_gnt    = b.mem_req && k == 1 + tv[i].gd;
        b.mem_rvalid = k == 2 + tv[i].gd + tv[i].rd;
        b.mem_rdata  = tv[i].data;
        if (b.mem_req && !saw) begin
          saw = 1;
          chk("vec_mem_addr", b.mem_addr, tv[i].pc & 32'hFFFFFFFC);
        end
        #1;
        if (b.instr_valid) begin
          cyc = k;
          break;
        end
        step();
      end
      clear_mem();
      chk("vec_latency", cyc, tv[i].lat);
      chk("vec_mem_used", saw, !tv[i].err);
      chk("vec_instr", b.instr, tv[i].ins);
      chk("vec_instr_pc", b.instr_pc, tv[i].pc);
      chk("vec_instr_err", b.instr_err, tv[i].err);
      pop1();
      chk("vec_popped", b.instr_valid, 0);
    end
    auto_mem = 1;
    send(32'h0, 10, ok);  chk("full_acc0", ok, 1);
    send(32'h4, 10, ok);  chk("full_acc4", ok, 1);
    send(32'h8, 10, ok);  chk("full_blocks8", ok, 0);
    #1;
    chk("full_pc_ready", b.pc_ready, 0);
    chk("full_head_pc", b.instr_pc, 0);
    b.instr_ready = 1'b1;
    b.pc_in = 32'h8;
    b.pc_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (b.instr_valid) begin
        got_pc.push_back(b.instr_pc);
        got_ins.push_back(b.instr);
      end
      acc = b.pc_valid && b.pc_ready;
      step();
      if (acc) b.pc_valid = 1'b0;
    end
    b.instr_ready = 1'b0;
    b.pc_valid = 1'b0;
    chk("order_count", got_pc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("order_pc", i < got_pc.size() ? got_pc[i] : 32'hFFFFFFFF, order[i]);
      chk("order_instr", i < got_ins.size() ? got_ins[i] : 32'hFFFFFFFF, memf(order[i]));
    end
    clear_mem();
    b.pc_in = 32'h10;
    b.pc_valid = 1'b1;
    #1 chk("drop_ready", b.pc_ready, 1);
    step();
    b.pc_valid = 1'b0;
    b.mem_gnt = 1'b1;
    #1 chk("drop_req", b.mem_req, 1);
    chk("drop_addr", b.mem_addr, 32'h10);
    step();
    b.mem_gnt = 1'b0;
    b.flush = 1'b1;
    #1 chk("drop_flush_ready", b.pc_ready, 0);
    step();
    b.flush = 1'b0;
    #1 chk("drop_state1", b.pc_ready, 0);
    step();
    b.mem_rvalid = 1'b1;
    b.mem_rdata = 32'hDEADBEEF;
    #1 chk("drop_state2", b.pc_ready, 0);
    step();
    b.mem_rvalid = 1'b0;
    #1 chk("drop_release", b.pc_ready, 1);
    chk("drop_discard", b.instr_valid, 0);
    auto_mem = 1;
    send(32'h20, 5, ok); chk("drop_next_acc", ok, 1);
    wait_valid(20);
    chk("drop_next_pc", b.instr_pc, 32'h20);
    chk("drop_next_instr", b.instr, memf(32'h20));
    chk("drop_next_err", b.instr_err, 0);
    pop1();
    clear_mem();
    send(32'h1, 5, ok);
    send(32'h2, 5, ok);
    #1 chk("fl_two_buf", b.instr_valid, 1);
    chk("fl_head_err", b.instr_err, 1);
    b.instr_ready = 1'b1;
    b.flush = 1'b1;
    step();
    b.instr_ready = 1'b0;
    b.flush = 1'b0;
    #1 chk("fl_empty", b.instr_valid, 0);
    chk("fl_ready_after", b.pc_ready, 1);
    b.flush = 1'b1;
    b.pc_in = 32'h54;
    b.pc_valid = 1'b1;
    #1 chk("fl_idle_block", b.pc_ready, 0);
    step();
    b.flush = 1'b0;
    b.pc_valid = 1'b0;
    #1 chk("fl_idle_noreq", b.mem_req, 0);
    chk("fl_idle_nopush", b.instr_valid, 0);
    b.pc_in = 32'h30;
    b.pc_valid = 1'b1;
    step();
    b.pc_valid = 1'b0;
    #1 chk("fl_req_up", b.mem_req, 1);
    b.flush = 1'b1;
    step();
    b.flush = 1'b0;
    #1 chk("fl_req_drop", b.mem_req, 0);
    chk("fl_req_idle", b.pc_ready, 1);
    b.pc_in = 32'h40;
    b.pc_valid = 1'b1;
    step();
    b.pc_valid = 1'b0;
    b.mem_gnt = 1'b1;
    step();
    b.mem_gnt = 1'b0;
    #1 chk("rw_wait", b.mem_req, 0);
    reset = 1'b1;
    #1;
    chk("rw_pc_ready", b.pc_ready, 0);
    chk("rw_mem_req", b.mem_req, 0);
    chk("rw_mem_addr", b.mem_addr, 0);
    chk("rw_instr_valid", b.instr_valid, 0);
    chk("rw_instr", b.instr, 0);
    chk("rw_instr_pc", b.instr_pc, 0);
    chk("rw_instr_err", b.instr_err, 0);
    step();
    reset = 1'b0;
    b.mem_rvalid = 1'b1;
    b.mem_rdata = 32'hBAD0BAD0;
    #1 chk("rw_rel_ready", b.pc_ready, 1);
    step();
    b.mem_rvalid = 1'b0;
    #1 chk("rw_stray_ignored", b.instr_valid, 0);
    auto_mem = 1;
    send(32'h0, 5, ok); chk("rw_next_acc", ok, 1);
    wait_valid(20);
    chk("rw_next_pc", b.instr_pc, 0);
    chk("rw_next_instr", b.instr, memf(32'h0));
    chk("rw_next_err", b.instr_err, 0);
    pop1();
    clear_mem();
    outst = 0; oreq = 0; opc = '0; mph = 0; mw = 0; maddr = '0;
    exq.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      b.pc_valid = 1'($urandom_range(0, 1));
      b.pc_in = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 4) == 0) b.pc_in[1:0] = 2'($urandom_range(1, 3));
      b.instr_ready = $urandom_range(0, 2) != 0;
      b.mem_gnt = 1'b0;
      b.mem_rvalid = 1'b0;
      b.mem_rdata = $urandom;
      if (mph == 0 && b.mem_req) begin
        mph = 1;
        mw = $urandom_range(0, 2);
      end
      if (mph == 1) begin
        if (mw == 0) begin
          b.mem_gnt = 1'b1;
          maddr = b.mem_addr;
        end else mw--;
      end else if (mph == 2) begin
        if (mw == 0) begin
          b.mem_rvalid = 1'b1;
          b.mem_rdata = memf(maddr);
        end else mw--;
      end
      #1;
      chk("rnd_pc_ready", b.pc_ready, !outst && exq.size() < DEPTH);
      chk("rnd_mem_req", b.mem_req, oreq);
      if (oreq) chk("rnd_mem_addr", b.mem_addr, opc);
      chk("rnd_instr_valid", b.instr_valid, exq.size() != 0);
      if (exq.size() != 0) begin
        chk("rnd_instr", b.instr, exq[0].ins);
        chk("rnd_instr_pc", b.instr_pc, exq[0].pc);
        chk("rnd_instr_err", b.instr_err, exq[0].err);
      end
      acc = b.pc_valid && !outst && exq.size() < DEPTH;
      pp = exq.size() != 0 && b.instr_ready;
      if (pp) void'(exq.pop_front());
      if (acc) begin
        if (b.pc_in[1:0] != 2'b00) exq.push_back('{NOP, b.pc_in, 1'b1});
        else begin
          outst = 1;
          oreq = 1;
          opc = b.pc_in;
        end
      end
      if (b.mem_gnt) begin
        mph = 2;
        mw = $urandom_range(0, 2);
        oreq = 0;
      end
      if (b.mem_rvalid) begin
        mph = 0;
        exq.push_back('{memf(opc), opc, 1'b0});
        outst = 0;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
